// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: top-level game-flow controller for the side-scroller.
// Runs title/play/pause/respawn/level-done/win/over, tracks lives and the
// current level, and raises the player/freeze/end-of-game flags plus
// one-cycle respawn and level-load pulses for the renderers.
module game_ctrl_fsm #(
  parameter int          COORD_W        = 12,
  parameter int          FINISH_X       = 2200,
  parameter int          LIVES          = 3,
  parameter int          LEVELS         = 4,
  parameter int          RESPAWN_FRAMES = 60,
  parameter int          LEVEL_FRAMES   = 120,
  parameter logic [7:0]  KEY_START      = 8'h2C,
  parameter logic [7:0]  KEY_PAUSE      = 8'h13
) (
  input  logic                                        Clk,
  input  logic                                        Reset,
  input  logic                                        frame_tick,
  input  logic [7:0]                                  keycode,
  input  logic                                        collisionFlag,
  input  logic [COORD_W-1:0]                          ballX,
  input  logic [COORD_W-1:0]                          scrollX,
  output logic                                        playerFlag,
  output logic                                        freeze,
  output logic                                        gameOver,
  output logic                                        gameWon,
  output logic [$clog2(LIVES+1)-1:0]                  lives_left,
  output logic [((LEVELS > 1) ? $clog2(LEVELS) : 1)-1:0] level,
  output logic                                        respawn,
  output logic                                        level_load
);

  localparam int LW      = $clog2(LIVES + 1);
  localparam int VW      = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int TMR_MAX = (RESPAWN_FRAMES > LEVEL_FRAMES) ? RESPAWN_FRAMES : LEVEL_FRAMES;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int SUM_W   = COORD_W + 1;

  localparam logic [LW-1:0]    LIVES_C    = LW'(LIVES);
  localparam logic [LW-1:0]    ONE_L      = LW'(1);
  localparam logic [LW-1:0]    ZERO_L     = LW'(0);
  localparam logic [VW-1:0]    LAST_LEVEL = VW'(LEVELS - 1);
  localparam logic [VW-1:0]    ONE_V      = VW'(1);
  localparam logic [VW-1:0]    ZERO_V     = VW'(0);
  localparam logic [TW-1:0]    RESPAWN_T  = TW'(RESPAWN_FRAMES);
  localparam logic [TW-1:0]    LEVEL_T    = TW'(LEVEL_FRAMES);
  localparam logic [TW-1:0]    ONE_T      = TW'(1);
  localparam logic [TW-1:0]    ZERO_T     = TW'(0);
  localparam logic [SUM_W-1:0] FINISH_C   = SUM_W'(FINISH_X);

  typedef enum logic [2:0] {
    S_START      = 3'd0,
    S_PLAY       = 3'd1,
    S_PAUSE      = 3'd2,
    S_RESPAWN    = 3'd3,
    S_LEVEL_DONE = 3'd4,
    S_WIN        = 3'd5,
    S_OVER       = 3'd6
  } state_t;

  // Flag decode {playerFlag, freeze, gameOver, gameWon} for a given state.
  function automatic logic [3:0] decode_flags(input state_t s);
    logic [3:0] f;
    case (s)
      S_PLAY:       f = 4'b1000;
      S_PAUSE:      f = 4'b1100;
      S_LEVEL_DONE: f = 4'b1100;
      S_WIN:        f = 4'b0101;
      S_OVER:       f = 4'b0110;
      S_START:      f = 4'b0100;
      S_RESPAWN:    f = 4'b0100;
      default:      f = 4'b0100;
    endcase
    return f;
  endfunction

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [LW-1:0]    lives_q, lives_d;
  logic [VW-1:0]    level_q, level_d;
  logic             respawn_q, respawn_d;
  logic             load_q, load_d;
  logic [7:0]       keycode_q;
  logic [3:0]       flags_q, flags_d;

  logic             start_press_s;
  logic             pause_press_s;
  logic [SUM_W-1:0] sum_s;
  logic             finish_s;

  // Edge-detect key presses against last cycle's keycode; the finish test is
  // done one bit wider than the coordinates so the sum can never wrap.
  always_comb begin
    start_press_s = (keycode == KEY_START) && (keycode_q != KEY_START);
    pause_press_s = (keycode == KEY_PAUSE) && (keycode_q != KEY_PAUSE);
    sum_s         = {1'b0, ballX} + {1'b0, scrollX};
    finish_s      = (sum_s >= FINISH_C);
  end

  // Next-state, counters and pulse generation for the game flow.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    lives_d   = lives_q;
    level_d   = level_q;
    respawn_d = 1'b0;
    load_d    = 1'b0;
    case (state_q)
      S_START, S_OVER, S_WIN: begin
        if (start_press_s) begin
          state_d = S_PLAY;
          lives_d = LIVES_C;
          level_d = ZERO_V;
          load_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_PLAY: begin
        // Collision outranks finish, which outranks a pause press.
        if (collisionFlag) begin
          if (lives_q > ONE_L) begin
            lives_d = lives_q - ONE_L;
            timer_d = RESPAWN_T;
            state_d = S_RESPAWN;
          end else begin
            lives_d = ZERO_L;
            state_d = S_OVER;
          end
        end else if (finish_s) begin
          if (level_q == LAST_LEVEL) begin
            state_d = S_WIN;
          end else begin
            timer_d = LEVEL_T;
            state_d = S_LEVEL_DONE;
          end
        end else if (pause_press_s) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_PAUSE: begin
        if (pause_press_s) begin
          state_d = S_PLAY;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_RESPAWN: begin
        // A zero timer is treated as expired so the count can never wrap.
        if (frame_tick) begin
          if (timer_q <= ONE_T) begin
            timer_d   = ZERO_T;
            state_d   = S_PLAY;
            respawn_d = 1'b1;
          end else begin
            timer_d = timer_q - ONE_T;
          end
        end else begin
          timer_d = timer_q;
        end
      end
      S_LEVEL_DONE: begin
        if (frame_tick) begin
          if (timer_q <= ONE_T) begin
            timer_d = ZERO_T;
            state_d = S_PLAY;
            level_d = level_q + ONE_V;
            load_d  = 1'b1;
          end else begin
            timer_d = timer_q - ONE_T;
          end
        end else begin
          timer_d = timer_q;
        end
      end
      default: begin
        state_d = S_START;
        timer_d = ZERO_T;
        lives_d = LIVES_C;
        level_d = ZERO_V;
      end
    endcase
    flags_d = decode_flags(state_d);
  end

  // State, counters, key history and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_START;
      timer_q   <= ZERO_T;
      lives_q   <= LIVES_C;
      level_q   <= ZERO_V;
      respawn_q <= 1'b0;
      load_q    <= 1'b0;
      keycode_q <= 8'h00;
      flags_q   <= 4'b0100;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      respawn_q <= respawn_d;
      load_q    <= load_d;
      keycode_q <= keycode;
      flags_q   <= flags_d;
    end
  end

  assign playerFlag = flags_q[3];
  assign freeze     = flags_q[2];
  assign gameOver   = flags_q[1];
  assign gameWon    = flags_q[0];
  assign lives_left = lives_q;
  assign level      = level_q;
  assign respawn    = respawn_q;
  assign level_load = load_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Scoreboard bench for game_ctrl_fsm: a driver issues one input set per cycle
// and pushes the outputs a rule-level reference model predicts; a monitor pops
// and compares after every rising edge.
module tb_game_ctrl_fsm;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic        collisionFlag = 1'b0;
  logic [11:0] ballX = 12'd0;
  logic [11:0] scrollX = 12'd0;
  logic        playerFlag, freeze, gameOver, gameWon;
  logic [1:0]  lives_left;
  logic [1:0]  level;
  logic        respawn, level_load;

  always #5 Clk = ~Clk;

  game_ctrl_fsm dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .collisionFlag(collisionFlag), .ballX(ballX), .scrollX(scrollX),
    .playerFlag(playerFlag), .freeze(freeze), .gameOver(gameOver),
    .gameWon(gameWon), .lives_left(lives_left), .level(level),
    .respawn(respawn), .level_load(level_load)
  );

  // {playerFlag, freeze, gameOver, gameWon, lives_left, level, respawn, level_load}
  logic [9:0] dut_vec;
  assign dut_vec = {playerFlag, freeze, gameOver, gameWon, lives_left, level, respawn, level_load};
  localparam logic [9:0] RST_VEC = {1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0};

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  // Reference model: game rules at the level of "mode", lives and level numbers.
  typedef enum {TITLE, PLAYING, PAUSED, DYING, BANNER, WON, LOST} mode_t;
  mode_t      m_mode = TITLE;
  int         m_lives = 3;
  int         m_level = 0;
  int         m_frames = 0;
  logic [7:0] m_prevkey = 8'h00;

  function automatic logic [9:0] expect_vec(mode_t md, int lv, int lev, bit rsp, bit ld);
    logic pf, fz, go, gw;
    logic [1:0] l2, v2;
    pf = (md == PLAYING) || (md == PAUSED) || (md == BANNER);
    fz = (md != PLAYING);
    go = (md == LOST);
    gw = (md == WON);
    l2 = lv[1:0];
    v2 = lev[1:0];
    return {pf, fz, go, gw, l2, v2, rsp, ld};
  endfunction

  task automatic model_step(input logic [7:0] k, input logic c, input logic [11:0] bx,
                            input logic [11:0] sx, input logic t, input logic r);
    bit sp, pp, fin, rsp, ld;
    if (r) begin
      m_mode = TITLE; m_lives = 3; m_level = 0; m_frames = 0; m_prevkey = 8'h00;
      exp_q.push_back(expect_vec(TITLE, 3, 0, 1'b0, 1'b0));
      return;
    end
    sp  = (k == 8'h2C) && (m_prevkey != 8'h2C);
    pp  = (k == 8'h13) && (m_prevkey != 8'h13);
    fin = (int'(bx) + int'(sx)) >= 2200;
    rsp = 1'b0;
    ld  = 1'b0;
    case (m_mode)
      TITLE, WON, LOST:
        if (sp) begin m_mode = PLAYING; m_lives = 3; m_level = 0; ld = 1'b1; end
      PLAYING:
        if (c) begin
          if (m_lives > 1) begin m_lives--; m_frames = 60; m_mode = DYING; end
          else begin m_lives = 0; m_mode = LOST; end
        end else if (fin) begin
          if (m_level == 3) m_mode = WON;
          else begin m_frames = 120; m_mode = BANNER; end
        end else if (pp) m_mode = PAUSED;
      PAUSED:
        if (pp) m_mode = PLAYING;
      DYING:
        if (t) begin
          if (m_frames == 1) begin m_mode = PLAYING; rsp = 1'b1; end
          else m_frames--;
        end
      BANNER:
        if (t) begin
          if (m_frames == 1) begin m_mode = PLAYING; m_level++; ld = 1'b1; end
          else m_frames--;
        end
      default: m_mode = TITLE;
    endcase
    m_prevkey = k;
    exp_q.push_back(expect_vec(m_mode, m_lives, m_level, rsp, ld));
  endtask

  // Drive one cycle of inputs on the falling edge and record the prediction.
  task automatic step(input logic [7:0] k, input logic c, input logic [11:0] bx,
                      input logic [11:0] sx, input logic t, input logic r);
    @(negedge Clk);
    keycode = k; collisionFlag = c; ballX = bx; scrollX = sx; frame_tick = t; Reset = r;
    if (r) begin
      #1;
      checks++;
      if (dut_vec !== RST_VEC) begin
        errors++;
        $display("FAIL reset_immediate t=%0t got=%b exp=%b", $time, dut_vec, RST_VEC);
      end
    end
    model_step(k, c, bx, sx, t, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
  endtask

  // Run random frame ticks until the model is back in play (bounded).
  task automatic wait_play();
    for (int i = 0; i < 1000 && m_mode != PLAYING; i++)
      step(8'h00, 1'b0, 12'd0, 12'd0, 1'($urandom_range(1, 0)), 1'b0);
    checks++;
    if (m_mode != PLAYING) begin
      errors++;
      $display("FAIL wait_play_timeout t=%0t got=%0d exp=%0d", $time, m_mode, PLAYING);
    end
  endtask

  // Monitor: compare every registered output just after each rising edge.
  logic [9:0] mon_exp;
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      if (dut_vec !== mon_exp) begin
        errors++;
        $display("FAIL outputs t=%0t got=%b exp=%b (pf fz go gw lives level rsp ld)",
                 $time, dut_vec, mon_exp);
      end
    end
  end

  logic [7:0]  cur_key;
  logic [11:0] rbx, rsx;
  int          pick;

  initial begin
    // Reset and start, then hold start: no extra level_load.
    step(8'h00, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 101; i++) step(8'h2C, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    idle(2);

    // Three hits: two respawns then game over, then restart.
    step(8'h00, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0);
    wait_play();
    step(8'h00, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0);
    wait_play();
    step(8'h00, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0);
    idle(5);
    step(8'h2C, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    idle(2);

    // Level progression with the finish boundary, then win at max coordinates.
    for (int lv = 0; lv < 3; lv++) begin
      step(8'h00, 1'b0, 12'd199, 12'd2000, 1'b0, 1'b0);
      step(8'h00, 1'b0, 12'd200, 12'd2000, 1'b0, 1'b0);
      wait_play();
    end
    step(8'h00, 1'b0, 12'd4095, 12'd4095, 1'b0, 1'b0);
    idle(3);
    step(8'h2C, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    idle(2);

    // Pause ignores collision, finish and start; second press resumes.
    step(8'h13, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(8'h13, 1'b1, 12'd300, 12'd2000, 1'b1, 1'b0);
    step(8'h2C, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    step(8'h13, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    idle(2);

    // Pause press with collision is discarded; collision beats finish.
    step(8'h13, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0);
    wait_play();
    step(8'h00, 1'b1, 12'd200, 12'd2000, 1'b0, 1'b0);
    idle(2);
    step(8'h2C, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    idle(2);

    // Reset in the middle of a respawn count.
    step(8'h00, 1'b1, 12'd0, 12'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(8'h00, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
    step(8'h00, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1);
    idle(3);

    // Randomised play.
    cur_key = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        pick = $urandom_range(5, 0);
        case (pick)
          0, 1:    cur_key = 8'h00;
          2, 3:    cur_key = 8'h2C;
          4:       cur_key = 8'h13;
          default: cur_key = 8'($urandom);
        endcase
      end
      if ($urandom_range(39, 0) == 0) begin
        rbx = 12'($urandom_range(4095, 1000));
        rsx = 12'($urandom_range(4095, 1000));
      end else begin
        rbx = 12'($urandom_range(500, 0));
        rsx = 12'($urandom_range(1000, 0));
      end
      step(cur_key, 1'($urandom_range(49, 0) == 0), rbx, rsx,
           1'($urandom_range(1, 0)), 1'($urandom_range(699, 0) == 0));
    end

    @(posedge Clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
